// File: rtl/cq_pkg.sv
// Shared circular-queue constants, pointer type and wrap-safe pointer arithmetic.
// Used by both the writer and the reader (cq_reader).
package cq_pkg;

    localparam int CQ_WIDTH = 16;
    localparam int CQ_DEPTH = 8;
    localparam int CQ_PTR_W = 3;

    typedef logic [CQ_PTR_W:0] ptr_t;

    // Modulo 2^(PTR_W+1) so the wrap bit cancels out.
    function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/cq_rd_mux.sv
// DEPTH:1 head-entry selector for the circular queue reader.
// Built as a balanced tree of 2:1 muxes; level 0 is the root.
import cq_pkg::*;

module cq_rd_mux #(
    parameter int WIDTH = CQ_WIDTH,
    parameter int DEPTH = CQ_DEPTH,
    parameter int PTR_W = CQ_PTR_W
) (
    input  logic [DEPTH*WIDTH-1:0] mem_flat,
    input  logic [PTR_W-1:0]       sel,
    output logic [WIDTH-1:0]       dout
);

    for (genvar d = 0; d <= PTR_W; d++) begin : g_lvl
        logic [WIDTH-1:0] n [1<<d];
        if (d == PTR_W) begin : g_leaf
            for (genvar k = 0; k < DEPTH; k++) begin : g_k
                assign n[k] = mem_flat[k*WIDTH +: WIDTH];
            end
        end else begin : g_node
            // The MSB of sel steers the root, the LSB the last level.
            for (genvar j = 0; j < (1<<d); j++) begin : g_j
                assign n[j] = sel[PTR_W-1-d] ? g_lvl[d+1].n[2*j+1]
                                             : g_lvl[d+1].n[2*j];
            end
        end
    end

    assign dout = g_lvl[0].n[0];

endmodule

// File: rtl/cq_reader.sv
// Circular queue dequeue side: read pointer plus registered FWFT output.
// Optional CQ_RD_FLUSH_EN adds a flush input that discards all held entries.
import cq_pkg::*;

module cq_reader #(
    parameter int WIDTH = CQ_WIDTH,
    parameter int DEPTH = CQ_DEPTH,
    parameter int PTR_W = CQ_PTR_W
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [PTR_W:0]         wr_ptr,
    input  logic [DEPTH*WIDTH-1:0] mem_flat,
    output logic [PTR_W:0]         rd_ptr,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   empty,
`ifdef CQ_RD_FLUSH_EN
    input  logic                   flush,
`endif
    output logic [PTR_W:0]         count
);

    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    logic [WIDTH-1:0] head;
    logic [PTR_W:0]   stor_cnt;
    logic             stor_empty;
    logic             load;

    cq_rd_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mux (
        .mem_flat (mem_flat),
        .sel      (rd_ptr_q[PTR_W-1:0]),
        .dout     (head)
    );

    assign stor_cnt   = wr_ptr - rd_ptr_q;
    assign stor_empty = (wr_ptr == rd_ptr_q);
    assign load       = !stor_empty && (!dout_valid_q || dout_ready);

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (load) begin
            dout_d       = head;
            rd_ptr_d     = rd_ptr_q + 1'b1;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
`ifdef CQ_RD_FLUSH_EN
        // Flush wins over load/pop; dout keeps its stale value.
        if (flush) begin
            rd_ptr_d     = wr_ptr;
            dout_d       = dout_q;
            dout_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_ptr_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign rd_ptr     = rd_ptr_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign empty      = !dout_valid_q;
    assign count      = stor_cnt + (PTR_W+1)'(dout_valid_q);

    // The writer must never get more than DEPTH entries ahead of rd_ptr.
    a_no_overrun: assert property (
        @(posedge clk) disable iff (!reset_)
        stor_cnt <= (PTR_W+1)'(DEPTH)
    );

endmodule
